ifid_skid_reg: RTL

- Pipeline boundary between instruction fetch and decode in the RISC-V core.
- Captures fetched {pc, inst} pairs and presents them to the decode stage: opcode/funct decode and immediate generation.
- Two-entry skid buffer with valid/ready handshakes on both sides, so fetch backpressure is fully registered.
- Supports a flush from the branch/jump resolution logic and injects a NOP whenever decode has no valid instruction.

---
 rtl/ifid_skid_reg.sv | 108 ++++++++++
 1 files changed

// File: rtl/ifid_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_skid_reg
// Description : IF/ID boundary; two-entry skid buffer with flush and NOP fill.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_skid_reg #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_inst,
    output logic            if_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [XLEN-1:0] id_inst,
    input  logic            id_ready,
    input  logic            flush,
    output logic [1:0]      occ
);

    localparam logic [XLEN-1:0] c_nop     = XLEN'(NOP_INST);
    localparam logic [XLEN-1:0] c_rst_pc  = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_main_inst;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_inst;

    logic w_main_valid;
    logic w_in_fire;
    logic w_out_fire;

    // Every output is a function of registered state only, so id_ready never
    // reaches if_ready combinationally.
    assign w_main_valid = (r_state != ST_EMPTY);
    assign if_ready     = (r_state != ST_FULL);
    assign w_in_fire    = if_valid & if_ready;
    assign w_out_fire   = w_main_valid & id_ready;

    assign id_valid = w_main_valid;
    assign id_pc    = r_main_pc;
    assign id_pc4   = r_main_pc + c_pc_step;
    assign id_inst  = w_main_valid ? r_main_inst : c_nop;
    assign occ      = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_pc   <= c_rst_pc;
            r_main_inst <= c_nop;
            r_skid_pc   <= c_rst_pc;
            r_skid_inst <= c_nop;
        end else if (flush) begin
            // Any instruction offered this cycle is dropped with the rest.
            r_state     <= ST_EMPTY;
            r_main_pc   <= c_rst_pc;
            r_main_inst <= c_nop;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main_pc   <= if_pc;
                        r_main_inst <= if_inst;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_pc   <= if_pc;
                        r_main_inst <= if_inst;
                    end else if (w_in_fire) begin
                        r_skid_pc   <= if_pc;
                        r_skid_inst <= if_inst;
                        r_state     <= ST_FULL;
                    end else if (w_out_fire) begin
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_main_pc   <= r_skid_pc;
                        r_main_inst <= r_skid_inst;
                        r_state     <= ST_BUSY;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
